// File: rtl/ex_unit_controller.sv
// Execute-stage dispatcher: starts one multicycle functional unit per op,
// tracks its completion or flush, and measures the op's latency.
module ex_unit_controller #(
   parameter int unsigned COUNTER_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     opValid,
   input  logic [2:0]               exUnitType,
   input  logic                     flush,
   output logic [4:0]               unitEnable,
   input  logic [4:0]               unitDone,
   output logic [4:0]               unitFlush,
   output logic                     stall,
   output logic                     opDone,
   output logic                     unknownUnit,
   output logic [COUNTER_WIDTH-1:0] cycleCount
);

   localparam int unsigned NumUnits = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state;
   state_t              stateNext;
   logic [NumUnits-1:0] opMask;
   logic [NumUnits-1:0] acceptMask;
   logic                firstExec;
   logic                legalType;
   logic                selDone;
   logic                accept;
   logic                flushReq;

   assign legalType  = (exUnitType != 3'd0) && (exUnitType <= 3'd5);
   assign acceptMask = NumUnits'(5'd1 << (exUnitType - 3'd1));
   // Completion is only honoured from the selected unit, and never in the enable cycle
   assign selDone    = (|(unitDone & opMask)) && !firstExec;

   // Next-state and combinational outputs
   always_comb begin
      stateNext   = state;
      accept      = 1'b0;
      flushReq    = 1'b0;
      case (state)
         IDLE: begin
            if (opValid && legalType && !flush) begin
               accept    = 1'b1;
               stateNext = EXEC;
            end
         end
         EXEC: begin
            if (flush) begin
               if (selDone) begin
                  stateNext = IDLE;
               end else begin
                  flushReq  = 1'b1;
                  stateNext = DRAIN;
               end
            end else if (selDone) begin
               stateNext = DONE;
            end
         end
         DRAIN: begin
            if (|(unitDone & opMask)) begin
               stateNext = IDLE;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
      stall       = rst && (accept || (state == EXEC) || (state == DRAIN));
      unknownUnit = rst && (state == IDLE) && opValid && (exUnitType > 3'd5);
      opDone      = (state == DONE) && !flush;
   end

   // State, registered pulses and saturating latency counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         opMask     <= '0;
         firstExec  <= 1'b0;
         unitEnable <= '0;
         unitFlush  <= '0;
         cycleCount <= '0;
      end else begin
         state      <= stateNext;
         firstExec  <= accept;
         unitEnable <= accept ? acceptMask : '0;
         unitFlush  <= flushReq ? opMask : '0;
         if (accept) begin
            opMask     <= acceptMask;
            cycleCount <= '0;
         end else if ((state == EXEC) && (cycleCount != '1)) begin
            cycleCount <= cycleCount + COUNTER_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_ex_unit_controller.sv
// Scoreboard bench for ex_unit_controller: two instances (16-bit and 4-bit
// counters) share stimulus and are checked against an op-level reference model.
module tb_ex_unit_controller;

   logic        clk;
   logic        rst;
   logic        opValid;
   logic [2:0]  exUnitType;
   logic        flush;
   logic [4:0]  unitDone;

   logic [4:0]  unitEnable, unitFlush;
   logic        stall, opDone, unknownUnit;
   logic [15:0] cycleCount;

   logic [4:0]  sUnitEnable, sUnitFlush;
   logic        sStall, sOpDone, sUnknownUnit;
   logic [3:0]  sCycleCount;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic [4:0]  en;
      logic [4:0]  fl;
      logic        st;
      logic        unk;
      logic        done;
      logic [15:0] cnt;
      logic [3:0]  cntSat;
   } exp_t;

   exp_t expQ[$];
   int   doneQ[$];

   // Reference model: the op currently owned by the controller
   int         mOp;        // unit type of the live op, 0 when none
   int         mAge;       // EXEC cycles already spent
   bit         mDrain;     // aborted, waiting for the unit to finish
   bit         mFinished;  // result is being reported this cycle
   logic [4:0] mEnMask, mFlMask;
   int         mCount, mCountSat;

   ex_unit_controller #(.COUNTER_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .opValid(opValid), .exUnitType(exUnitType),
      .flush(flush), .unitEnable(unitEnable), .unitDone(unitDone),
      .unitFlush(unitFlush), .stall(stall), .opDone(opDone),
      .unknownUnit(unknownUnit), .cycleCount(cycleCount)
   );

   ex_unit_controller #(.COUNTER_WIDTH(4)) dutSat (
      .clk(clk), .rst(rst), .opValid(opValid), .exUnitType(exUnitType),
      .flush(flush), .unitEnable(sUnitEnable), .unitDone(unitDone),
      .unitFlush(sUnitFlush), .stall(sStall), .opDone(sOpDone),
      .unknownUnit(sUnknownUnit), .cycleCount(sCycleCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] oneHot(input int k);
      return 5'(1 << (k - 1));
   endfunction

   task automatic modelReset();
      mOp = 0; mAge = 0; mDrain = 0; mFinished = 0;
      mEnMask = '0; mFlMask = '0; mCount = 0; mCountSat = 0;
   endtask

   // Drive one cycle of inputs, predict this cycle's outputs, advance the model
   task automatic step(input logic r, input logic v, input logic [2:0] t,
                       input logic f, input logic [4:0] d);
      exp_t       e;
      bit         legal, idle, doneSeen;
      logic [4:0] nextEn, nextFl;
      rst = r; opValid = v; exUnitType = t; flush = f; unitDone = d;
      legal = (t >= 3'd1) && (t <= 3'd5);
      idle  = (mOp == 0) && !mFinished;
      e.st     = r && ((idle && v && legal && !f) || (mOp != 0));
      e.unk    = r && idle && v && (t >= 3'd6);
      e.en     = mEnMask;
      e.fl     = mFlMask;
      e.done   = mFinished && !f;
      e.cnt    = 16'(mCount);
      e.cntSat = 4'(mCountSat);
      expQ.push_back(e);
      if (e.done) doneQ.push_back(mCount);
      @(posedge clk);
      if (!r) begin
         modelReset();
      end else begin
         nextEn = '0;
         nextFl = '0;
         if (mFinished) begin
            mFinished = 0;
         end else if (mOp == 0) begin
            if (v && legal && !f) begin
               mOp = int'(t); mAge = 0; mDrain = 0;
               mCount = 0; mCountSat = 0;
               nextEn = oneHot(int'(t));
            end
         end else if (mDrain) begin
            if (d[mOp-1]) mOp = 0;
         end else begin
            doneSeen = (mAge > 0) && d[mOp-1];
            if (mCount < 65535) mCount++;
            if (mCountSat < 15) mCountSat++;
            mAge++;
            if (f && !doneSeen) begin
               nextFl = oneHot(mOp);
               mDrain = 1;
            end else if (f) begin
               mOp = 0;
            end else if (doneSeen) begin
               mFinished = 1;
               mOp = 0;
            end
         end
         mEnMask = nextEn;
         mFlMask = nextFl;
      end
      #1;
   endtask

   // Monitor: per-cycle expectations, plus completion events keyed on opDone
   initial begin
      exp_t e;
      int   c;
      forever begin
         @(negedge clk);
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            chk("unitEnable",   32'(unitEnable),   32'(e.en));
            chk("unitFlush",    32'(unitFlush),    32'(e.fl));
            chk("stall",        32'(stall),        32'(e.st));
            chk("unknownUnit",  32'(unknownUnit),  32'(e.unk));
            chk("opDone",       32'(opDone),       32'(e.done));
            chk("cycleCount",   32'(cycleCount),   32'(e.cnt));
            chk("sat_unitEnable", 32'(sUnitEnable), 32'(e.en));
            chk("sat_unitFlush",  32'(sUnitFlush),  32'(e.fl));
            chk("sat_stall",      32'(sStall),      32'(e.st));
            chk("sat_opDone",     32'(sOpDone),     32'(e.done));
            chk("sat_cycleCount", 32'(sCycleCount), 32'(e.cntSat));
         end
         if (opDone === 1'b1) begin
            if (doneQ.size() == 0) begin
               chk("unexpected_opDone", 32'(opDone), 32'd0);
            end else begin
               c = doneQ.pop_front();
               chk("done_latency", 32'(cycleCount), 32'(c));
            end
         end
      end
   end

   initial begin
      rst = 1'b0; opValid = 1'b0; exUnitType = '0; flush = 1'b0; unitDone = '0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);

      // MulDiv: accept, done on the fourth EXEC cycle
      step(1, 1, 5, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 5'b10000);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);

      // Fp64 flushed on second EXEC cycle, unit finishes three cycles later
      step(1, 1, 3, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 0, 5'b11011);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 5'b00100);
      step(1, 0, 0, 0, 0);

      // LoadStore flush and done together, then a fresh op
      step(1, 1, 4, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 5'b01000);
      step(1, 0, 0, 0, 0);
      step(1, 1, 2, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 5'b00010);
      step(1, 0, 0, 0, 0);

      // Illegal and None types
      step(1, 1, 6, 0, 0);
      step(1, 1, 7, 1, 0);
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 5'b11111);

      // Counter saturation: 20 EXEC cycles
      step(1, 1, 1, 0, 0);
      for (int i = 0; i < 19; i++) step(1, 0, 0, 0, 5'b11110);
      step(1, 0, 0, 0, 5'b00001);
      step(1, 0, 0, 0, 0);

      // Reset mid-op, then spurious completions
      step(1, 1, 2, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 1, 2, 0, 0);
      step(1, 0, 0, 0, 5'b11111);
      step(1, 0, 0, 0, 5'b11111);

      // Flush blocks acceptance, flush in enable cycle, flush ignored in DRAIN, flush in DONE
      step(1, 1, 2, 1, 0);
      step(1, 1, 2, 0, 0);
      step(1, 0, 0, 1, 5'b00010);
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 0, 5'b00010);
      step(1, 1, 1, 0, 0);
      step(1, 0, 0, 0, 5'b00001);
      step(1, 0, 0, 0, 5'b00001);
      step(1, 1, 1, 1, 0);
      step(1, 0, 0, 0, 0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] d;
         d = '0;
         for (int b = 0; b < 5; b++) d[b] = ($urandom_range(0, 99) < 30);
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7),
              3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0), d);
      end

      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("pending_completions", 32'(doneQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
